bp_fe_bht: RTL

BP_FE_BHT -- requirements
Module: bp_fe_bht

---
 rtl/bp_fe_bht_if.sv | 36 +++
 rtl/bp_fe_bht.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_if.sv
// Read/update port bundle for the branch history table.
// The slave side is the table. The master side is whoever issues lookups and training updates.
interface bp_fe_bht_if #(
    parameter int bht_idx_width_p = 4
);
    logic                       ready_o;
    logic                       w_v_i;
    logic [bht_idx_width_p-1:0] idx_w_i;
    logic                       taken_i;
    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] idx_r_i;
    logic                       predict_v_o;
    logic                       predict_o;

    modport slave (
        output ready_o,
        output predict_v_o,
        output predict_o,
        input  w_v_i,
        input  idx_w_i,
        input  taken_i,
        input  r_v_i,
        input  idx_r_i
    );

    modport master (
        input  ready_o,
        input  predict_v_o,
        input  predict_o,
        output w_v_i,
        output idx_w_i,
        output taken_i,
        output r_v_i,
        output idx_r_i
    );
endinterface

// File: rtl/bp_fe_bht.sv
// Branch history table with saturating counters for front-end direction prediction.
// In bimodal mode the table is filled with weakly-not-taken after reset, one entry per cycle.
// In the two static modes there is no table, and the block answers with a constant.
module bp_fe_bht #(
    parameter int    bht_idx_width_p = 4,
    parameter int    ctr_width_p     = 2,
    parameter string bp_type_p       = "bimodal"
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    bp_fe_bht_if.slave  bus
);
    localparam int els_lp           = 2 ** bht_idx_width_p;
    localparam bit is_bimodal_lp    = (bp_type_p == "bimodal");
    localparam bit is_taken_lp      = (bp_type_p == "always_taken");
    localparam bit is_not_taken_lp  = (bp_type_p == "always_not_taken");
    localparam logic [bht_idx_width_p-1:0] last_idx_lp = '1;

    // Reject configurations the table cannot represent before anything is built
    if (!(is_bimodal_lp || is_taken_lp || is_not_taken_lp)) begin : g_bad_type
        $fatal(1, "bp_fe_bht: unsupported bp_type_p '%s'", bp_type_p);
    end
    if (ctr_width_p < 1 || ctr_width_p > 4) begin : g_bad_ctr
        $fatal(1, "bp_fe_bht: ctr_width_p %0d outside 1..4", ctr_width_p);
    end

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [bht_idx_width_p-1:0] init_ptr_q, init_ptr_d;
    logic                       predict_v_q, predict_v_d;
    logic                       predict_q, predict_d;
    logic                       rd_msb;

    if (is_bimodal_lp) begin : g_table
        localparam logic [ctr_width_p-1:0] init_lp =
            (ctr_width_p == 1) ? '0 : ctr_width_p'((2 ** (ctr_width_p - 1)) - 1);
        localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;

        logic [ctr_width_p-1:0] table_q [els_lp];
        logic [ctr_width_p-1:0] cur_ctr;
        logic [ctr_width_p-1:0] upd_ctr;

        // Saturating step of the counter being trained, never wrapping at either end
        always_comb begin
            cur_ctr = table_q[bus.idx_w_i];
            upd_ctr = cur_ctr;
            if (bus.taken_i) begin
                if (cur_ctr != ctr_max_lp) begin
                    upd_ctr = cur_ctr + ctr_width_p'(1);
                end
            end else begin
                if (cur_ctr != '0) begin
                    upd_ctr = cur_ctr - ctr_width_p'(1);
                end
            end
        end

        // Table storage: sweep the init value during INIT, otherwise apply the training update
        always_ff @(posedge clk_i) begin
            if (state_q == INIT) begin
                table_q[init_ptr_q] <= init_lp;
            end else if (bus.w_v_i) begin
                table_q[bus.idx_w_i] <= upd_ctr;
            end
        end

        // The prediction is taken from the stored value, so a same-cycle update is not yet visible
        assign rd_msb = table_q[bus.idx_r_i][ctr_width_p-1];
    end else begin : g_static
        assign rd_msb = is_taken_lp;
    end

    // Next state, init sweep and prediction capture
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        predict_v_d = 1'b0;
        predict_d   = predict_q;
        case (state_q)
            INIT: begin
                if (!is_bimodal_lp) begin
                    state_d = READY;
                end else begin
                    init_ptr_d = init_ptr_q + bht_idx_width_p'(1);
                    if (init_ptr_q == last_idx_lp) begin
                        state_d    = READY;
                        init_ptr_d = '0;
                    end
                end
            end
            READY: begin
                if (bus.r_v_i) begin
                    predict_v_d = 1'b1;
                    predict_d   = rd_msb;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Control and prediction registers, all cleared as soon as reset is asserted
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            predict_v_q <= 1'b0;
            predict_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            predict_v_q <= predict_v_d;
            predict_q   <= predict_d;
        end
    end

    assign bus.ready_o     = (state_q == READY);
    assign bus.predict_v_o = predict_v_q;
    assign bus.predict_o   = predict_q;
endmodule
